// File: rtl/c2h_pkg.sv
// c2h_pkg: shared types and constants for the C2H record scheduler.
//   state_t   - scheduler FSM encoding (3 bits)
//   REC_W     - useful record payload width produced by the packer
//   BEAT_W    - AXI-Stream beat width of the XDMA C2H port
//   DEF_BEATS - default stream beats per padded record (BEATS*BEAT_W >= REC_W)
package c2h_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SEND  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

  localparam int REC_W     = 4072;
  localparam int BEAT_W    = 512;
  localparam int DEF_BEATS = 8;

endpackage

// File: rtl/c2h_rr_arb.sv
// c2h_rr_arb: round-robin arbiter over NUM_SRC requesters.
// The winner is the first set request at or after the pointer (wrapping).
// The pointer only moves when the caller accepts the grant (take), and then
// lands one past the winner so the winner gets lowest priority next time.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (pointer -> 0)
//   req        - per-source request
//   take       - grant accepted this cycle; advance pointer
//   gnt        - one-hot grant (combinational)
//   gnt_idx    - binary index of the winner (combinational)
//   gnt_any    - some request is set
module c2h_rr_arb #(
  parameter int NUM_SRC = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         req,
  input  logic                       take,
  output logic [NUM_SRC-1:0]         gnt,
  output logic [$clog2(NUM_SRC)-1:0] gnt_idx,
  output logic                       gnt_any
);

  localparam int IW = $clog2(NUM_SRC);

  logic [IW-1:0] ptr;

  always_comb begin
    int s;
    s       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      s = int'(ptr) + i;
      if (s >= NUM_SRC) s = s - NUM_SRC;
      if (!gnt_any && req[s]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(s);
      end
    end
    gnt          = '0;
    gnt[gnt_idx] = gnt_any;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (take && gnt_any) begin
      // NUM_SRC need not be a power of two, so wrap explicitly
      if (int'(gnt_idx) == NUM_SRC - 1) ptr <= '0;
      else                              ptr <= gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/c2h_pack_sched.sv
// c2h_pack_sched: scheduler between the capture sources, the record packer
// and the XDMA C2H AXI-Stream port.
//   - round-robin grants one capture source at a time onto the packer
//   - asks the packer to load (pk_out_enable) and waits for pk_data_valid,
//     with a TIMEOUT watchdog that raises a sticky stall_err and flushes
//   - streams the padded record as BEATS beats by driving beat_idx to the
//     external beat mux, with tvalid/tlast generated here
//   - pulses pk_data_next after the last beat and counts finished records
//   - ctrl_flush aborts the current record and clears the packer (pk_en)
// Ports:
//   m_axis_c2h_aclk / m_axis_c2h_areset  clock, sync active-high reset
//   ctrl_run, ctrl_flush                 run level, flush pulse
//   src_valid / src_ready / src_sel      source requests, grant pulse, mux index
//   pk_out_enable, pk_data_valid,
//   pk_data_next, pk_en                  packer handshake and clear
//   m_axis_c2h_tvalid/tready/tlast       stream handshake
//   beat_idx                             beat select for the datapath mux
//   busy, rec_count, stall_err           status
// A flush during SEND truncates the packet without tlast; the DMA channel
// has to be reset by software afterwards.
module c2h_pack_sched
  import c2h_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int BEATS   = DEF_BEATS,
  parameter int TIMEOUT = 1024
) (
  input  logic                       m_axis_c2h_aclk,
  input  logic                       m_axis_c2h_areset,
  input  logic                       ctrl_run,
  input  logic                       ctrl_flush,
  input  logic [NUM_SRC-1:0]         src_valid,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic [$clog2(NUM_SRC)-1:0] src_sel,
  output logic                       pk_out_enable,
  input  logic                       pk_data_valid,
  output logic                       pk_data_next,
  output logic                       pk_en,
  output logic                       m_axis_c2h_tvalid,
  input  logic                       m_axis_c2h_tready,
  output logic                       m_axis_c2h_tlast,
  output logic [$clog2(BEATS)-1:0]   beat_idx,
  output logic                       busy,
  output logic [31:0]                rec_count,
  output logic                       stall_err
);

  localparam int SW = $clog2(NUM_SRC);
  localparam int BW = $clog2(BEATS);
  localparam int WW = $clog2(TIMEOUT) + 1;

  state_t         state;
  logic [WW-1:0]  wait_cnt;

  logic [NUM_SRC-1:0] gnt;
  logic [SW-1:0]      gnt_idx;
  logic               gnt_any;
  logic               take;
  logic               last_beat;

  // A flush in IDLE takes priority over a new grant, so the pointer must
  // not move in that cycle either.
  assign take = (state == ST_IDLE) && ctrl_run && !ctrl_flush;

  c2h_rr_arb #(
    .NUM_SRC (NUM_SRC)
  ) u_arb (
    .clk     (m_axis_c2h_aclk),
    .rst     (m_axis_c2h_areset),
    .req     (src_valid),
    .take    (take),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign last_beat = (beat_idx == BW'(BEATS - 1));

  // Decoded from state. pk_out_enable also drops in the cycle the packer
  // reports valid so it is not asked to load a second record.
  assign pk_out_enable     = (state == ST_LOAD) && !pk_data_valid;
  assign m_axis_c2h_tvalid = (state == ST_SEND);
  assign m_axis_c2h_tlast  = (state == ST_SEND) && last_beat;
  assign pk_data_next      = (state == ST_NEXT);
  assign pk_en             = (state == ST_FLUSH);
  assign busy              = (state != ST_IDLE);

  always_ff @(posedge m_axis_c2h_aclk) begin
    if (m_axis_c2h_areset) begin
      state     <= ST_IDLE;
      src_ready <= '0;
      src_sel   <= '0;
      beat_idx  <= '0;
      wait_cnt  <= '0;
      rec_count <= '0;
      stall_err <= 1'b0;
    end else begin
      src_ready <= '0;
      unique case (state)
        ST_IDLE: begin
          if (ctrl_flush) begin
            state <= ST_FLUSH;
          end else if (ctrl_run && gnt_any) begin
            src_ready <= gnt;
            src_sel   <= gnt_idx;
            wait_cnt  <= '0;
            state     <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (ctrl_flush) begin
            state <= ST_FLUSH;
          end else if (pk_data_valid) begin
            beat_idx <= '0;
            state    <= ST_SEND;
          end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
            stall_err <= 1'b1;
            state     <= ST_FLUSH;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end

        ST_SEND: begin
          // Flush wins even over a completing last beat: the record is
          // dropped and not counted.
          if (ctrl_flush) begin
            state <= ST_FLUSH;
          end else if (m_axis_c2h_tready) begin
            if (last_beat) begin
              beat_idx <= '0;
              state    <= ST_NEXT;
            end else begin
              beat_idx <= beat_idx + BW'(1);
            end
          end
        end

        ST_NEXT: begin
          rec_count <= rec_count + 32'd1;
          state     <= ST_IDLE;
        end

        ST_FLUSH: begin
          beat_idx <= '0;
          wait_cnt <= '0;
          state    <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/c2h_pack_sched.md
Name: c2h_pack_sched

Overview:
- Controller sitting between the DUT capture sources, the record packer and the XDMA C2H AXI-Stream port.
- Round-robin arbitrates NUM_SRC capture sources onto the single packer and sequences the packer enable/next handshake.
- Slices each 4096-bit padded record into BEATS stream beats by driving a beat index to an external beat mux, and generates tvalid/tlast.
- Provides flush, a load-timeout watchdog and a record counter.

Parameters:
NUM_SRC, 2, number of capture sources sharing the packer (2..8)
BEATS, 8, stream beats per record (record padded to BEATS*512 bits)
TIMEOUT, 1024, max cycles waiting for packer data_valid before error/flush

Ports:
m_axis_c2h_aclk  in  1  clock, all logic rising-edge
m_axis_c2h_areset  in  1  synchronous active-high reset
ctrl_run  in  1  level; 0 = stop granting new sources (finish current record)
ctrl_flush  in  1  pulse; abort current record, clear packer
src_valid  in  NUM_SRC  per-source record pending
src_ready  out  NUM_SRC  one-hot, one-cycle grant/accept pulse
src_sel  out  $clog2(NUM_SRC)  source index to the packer input mux; held for the whole record
pk_out_enable  out  1  packer load request
pk_data_valid  in  1  packer one-cycle "record latched" pulse
pk_data_next  out  1  one-cycle pulse: record consumed, advance packer
pk_en  out  1  one-cycle packer clear
m_axis_c2h_tvalid  out  1  stream valid
m_axis_c2h_tready  in  1  stream ready
m_axis_c2h_tlast  out  1  last beat of record
beat_idx  out  $clog2(BEATS)  beat select for the external mux
busy  out  1  state != IDLE
rec_count  out  32  records fully sent, wraps at 2^32
stall_err  out  1  sticky load timeout; cleared only by reset

Behaviour:
- Reset values: all outputs 0; src_sel = 0; round-robin pointer = 0; state = IDLE.
- FSM states: IDLE, LOAD, SEND, NEXT, FLUSH.
- IDLE:
  - If ctrl_run and any src_valid: pick the first set bit at or after the RR pointer (wrapping). Pulse src_ready for that source and latch src_sel. Set the pointer to winner+1, wrapping at NUM_SRC. Go to LOAD.
  - No grant while ctrl_run = 0.
- LOAD:
  - pk_out_enable = 1 until pk_data_valid is seen.
  - On pk_data_valid: pk_out_enable drops that same cycle (combinational from state), beat_idx = 0, go to SEND.
  - Wait counter increments each LOAD cycle. When it reaches TIMEOUT-1 without valid: set stall_err, go to FLUSH.
- SEND:
  - tvalid = 1; tlast = (beat_idx == BEATS-1).
  - On tvalid & tready: beat_idx increments. On the last beat go to NEXT.
  - tvalid stays high and beat_idx stays stable while tready = 0 (AXIS rule). No bubble between beats.
- NEXT: pulse pk_data_next for one cycle; rec_count += 1; go to IDLE. Minimum gap between records is 2 cycles.
- FLUSH: pk_en = 1 for one cycle; beat_idx = 0; wait counter cleared; go to IDLE. Partial records are dropped and not counted.
- ctrl_flush in LOAD or SEND: go to FLUSH next cycle and deassert tvalid.
  - Known risk: a flush mid-SEND truncates the packet without tlast. Software must reset the DMA channel after a flush.
- ctrl_flush in IDLE also runs FLUSH. ctrl_flush in NEXT or FLUSH is ignored.
- Simultaneous ctrl_flush and tready handshake on the last beat: the beat completes, flush wins, FLUSH follows, rec_count is not incremented.
- Reset mid-operation: immediate return to reset values next edge. Reset does not pulse pk_en; the packer has its own reset.
- src_valid dropping after grant has no effect; the record is already committed.

Decomposition:
- Shared package c2h_pkg holds:
  - state enum (IDLE=0, LOAD=1, SEND=2, NEXT=3, FLUSH=4, 3 bits)
  - REC_W = 4072 and BEAT_W = 512 constants
  - the default BEATS value
- One natural sub-module, c2h_rr_arb: a NUM_SRC round-robin arbiter with pointer update on grant.
- The beat mux stays outside this block, in the datapath.

Test Plan:
- Reset, then src_valid = 2'b01 with ctrl_run = 1 and tready always 1 -> src_ready[0] pulse, src_sel = 0, 8 beats with tlast on beat_idx = 7, one pk_data_next pulse, rec_count = 1.
- src_valid = 2'b11 held for 4 records -> grant order 0,1,0,1, rec_count = 4.
- tready toggling 1-0-1-0 during SEND -> beat_idx advances only on handshake, tvalid never drops, exactly 8 handshakes, tlast only on the 8th.
- pk_data_valid never arrives, TIMEOUT = 16 -> after 16 LOAD cycles stall_err = 1, pk_en one-cycle pulse, state IDLE, rec_count unchanged; stall_err still 1 after next record.
- ctrl_flush at beat 3 of SEND -> tvalid 0 next cycle, pk_en pulse, no pk_data_next, rec_count unchanged, next grant proceeds normally from beat 0.
- ctrl_run = 0 with src_valid = 2'b01 -> no src_ready; raise ctrl_run -> grant on the next cycle.
